proc_test_sequencer: RTL
========================

PROC_TEST_SEQUENCER -- requirements
Module: proc_test_sequencer

Interface
REQ-001 NUM_PROGS, default 4: number of programs in the test table (1..16).
REQ-002 PC_W, default 64: program counter width.
REQ-003 DATA_W, default 64: result (MemtoRegOut) width.
REQ-004 WDOG_W, default 16: watchdog counter width.
REQ-005 WDOG_LIMIT, default 255: cycles in RUN before timeout; must be less than 2^WDOG_W.
REQ-006 RST_CYCLES, default 2: cycles cpu_resetl is held low per program (>=1).
REQ-007 CLK  in  1  single clock; all state updates on its rising edge.
REQ-008 resetl  in  1  asynchronous, active-low reset.
REQ-009 start  in  1  one-cycle pulse; begins a full test run.
REQ-010 prog_start  in  NUM_PROGS*PC_W  start PC table; entry i at bits [i*PC_W +: PC_W].
REQ-011 prog_end  in  NUM_PROGS*PC_W  end-PC table; same packing.
REQ-012 prog_expect  in  NUM_PROGS*DATA_W  expected-result table; same packing.
REQ-013 currentpc  in  PC_W  PC reported by the CPU under test.
REQ-014 MemtoRegOut  in  DATA_W  writeback value reported by the CPU.
REQ-015 cpu_resetl  out  1  active-low reset driven to the CPU.
REQ-016 cpu_startpc  out  PC_W  start PC driven to the CPU.
REQ-017 busy  out  1  high in every state except IDLE and DONE.
REQ-018 done  out  1  high in DONE.
REQ-019 all_passed  out  1  done AND pass_count == NUM_PROGS.
REQ-020 pass_count  out  5  programs passed in the current run.
REQ-021 fail_mask  out  NUM_PROGS  bit i set when program i failed.
REQ-022 timeout_mask  out  NUM_PROGS  bit i set when program i hit the watchdog.
REQ-023 prog_idx  out  4  index of the current program.

Function
REQ-024 The block SHALL implement the states IDLE, CPURST, RUN, CHECK, NEXT and DONE.
REQ-025 IDLE/DONE + start: clear pass_count, fail_mask, timeout_mask, prog_idx and the watchdog, then go to CPURST; start in any other state SHALL be ignored.
REQ-026 CPURST: cpu_resetl=0 for exactly RST_CYCLES cycles, then RUN; cpu_startpc = prog_start[prog_idx] whenever not in IDLE.
REQ-027 RUN: cpu_resetl=1 and the watchdog increments by 1 each cycle, starting from 0 on entry.
REQ-028 RUN: if currentpc >= prog_end[prog_idx] (unsigned), the block SHALL go to CHECK and latch MemtoRegOut in that cycle.
REQ-029 RUN: if the watchdog equals WDOG_LIMIT and the end PC is not reached, the block SHALL set fail_mask[idx] and timeout_mask[idx] and go to NEXT.
REQ-030 If the end PC is reached and the watchdog limit hits in the same cycle, reaching the end PC SHALL win and no timeout is recorded.
REQ-031 CHECK (1 cycle): latched value == prog_expect[idx] increments pass_count, otherwise sets fail_mask[idx]; then NEXT.
REQ-032 NEXT (1 cycle): if idx == NUM_PROGS-1, go to DONE; else idx+1, watchdog=0, go to CPURST.
REQ-033 DONE SHALL hold all results stable until the next start.
REQ-034 Minimum per-program latency SHALL be RST_CYCLES+3 cycles (end PC met on the first RUN cycle).
REQ-035 pass_count SHALL never exceed NUM_PROGS, and popcount(fail_mask) + pass_count SHALL equal the number of programs completed.

Reset
REQ-036 resetl low SHALL immediately force IDLE, cpu_resetl=0, cpu_startpc=0, busy=0, done=0, all_passed=0, pass_count=0, fail_mask=0, timeout_mask=0, prog_idx=0 and watchdog=0.
REQ-037 Reset asserted mid-run SHALL discard all partial results; after release the block SHALL stay in IDLE with cpu_resetl=0 until start.

Verification
REQ-038 NUM_PROGS=1, start=0, end=0x30, expect=0xF; CPU model counts PC +4 per cycle and reports 0xF -> done, pass_count=1, all_passed=1, RUN lasts 12 cycles.
REQ-039 Program 2 of 4 reports 0xE against an expected 0xF -> fail_mask=4'b0100, timeout_mask=0, pass_count=3, all_passed=0.
REQ-040 Program 1 has its PC stuck at 0x8 -> after 255 RUN cycles timeout_mask=4'b0010, and the run continues to program 2.
REQ-041 End PC reached on the same cycle the watchdog equals WDOG_LIMIT -> CHECK is entered and timeout_mask bit stays 0.
REQ-042 resetl pulsed low during RUN of program 2 -> all outputs at reset values asynchronously; start afterwards reruns from program 0.
REQ-043 start pulsed while busy -> no effect; start pulsed in DONE -> results cleared and a new run begins with cpu_resetl low for RST_CYCLES cycles.

Source files
------------

// File: rtl/proc_test_sequencer.sv
// Sequences a table of CPU test programs: resets the CPU at each start PC, waits for the
// end PC or a watchdog timeout, compares the writeback value and accumulates results.
module proc_test_sequencer #(
  parameter int unsigned NUM_PROGS  = 4,
  parameter int unsigned PC_W       = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned WDOG_W     = 16,
  parameter int unsigned WDOG_LIMIT = 255,
  parameter int unsigned RST_CYCLES = 2
) (
  input  logic                        CLK,
  input  logic                        resetl,
  input  logic                        start,
  input  logic [NUM_PROGS*PC_W-1:0]   prog_start,
  input  logic [NUM_PROGS*PC_W-1:0]   prog_end,
  input  logic [NUM_PROGS*DATA_W-1:0] prog_expect,
  input  logic [PC_W-1:0]             currentpc,
  input  logic [DATA_W-1:0]           MemtoRegOut,
  output logic                        cpu_resetl,
  output logic [PC_W-1:0]             cpu_startpc,
  output logic                        busy,
  output logic                        done,
  output logic                        all_passed,
  output logic [4:0]                  pass_count,
  output logic [NUM_PROGS-1:0]        fail_mask,
  output logic [NUM_PROGS-1:0]        timeout_mask,
  output logic [3:0]                  prog_idx
);

  typedef enum logic [2:0] {StIdle, StCpuRst, StRun, StCheck, StNext, StDone} state_e;

  localparam int unsigned RstCntW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RstCntW-1:0] RstLast   = RstCntW'(RST_CYCLES - 1);
  localparam logic [WDOG_W-1:0]  WdogLimit = WDOG_W'(WDOG_LIMIT);
  localparam logic [3:0]         LastIdx   = 4'(NUM_PROGS - 1);
  localparam logic [4:0]         NumProgs  = 5'(NUM_PROGS);

  state_e                state_q, state_d;
  logic [3:0]            idx_q, idx_d;
  logic [4:0]            pass_q, pass_d;
  logic [NUM_PROGS-1:0]  fail_q, fail_d;
  logic [NUM_PROGS-1:0]  to_q, to_d;
  logic [WDOG_W-1:0]     wdog_q, wdog_d;
  logic [RstCntW-1:0]    rst_cnt_q, rst_cnt_d;
  logic [DATA_W-1:0]     result_q, result_d;

  logic [PC_W-1:0]       cur_start;
  logic [PC_W-1:0]       cur_end;
  logic [DATA_W-1:0]     cur_expect;
  logic [NUM_PROGS-1:0]  idx_onehot;

  assign cur_start  = prog_start[32'(idx_q) * PC_W +: PC_W];
  assign cur_end    = prog_end[32'(idx_q) * PC_W +: PC_W];
  assign cur_expect = prog_expect[32'(idx_q) * DATA_W +: DATA_W];
  assign idx_onehot = NUM_PROGS'(1) << idx_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    to_d      = to_q;
    wdog_d    = wdog_q;
    rst_cnt_d = rst_cnt_q;
    result_d  = result_q;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d   = StCpuRst;
          idx_d     = '0;
          pass_d    = '0;
          fail_d    = '0;
          to_d      = '0;
          wdog_d    = '0;
          rst_cnt_d = '0;
        end
      end
      StCpuRst: begin
        wdog_d = '0;
        if (rst_cnt_q == RstLast) begin
          rst_cnt_d = '0;
          state_d   = StRun;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      StRun: begin
        // End-PC check has priority over the watchdog on the same cycle.
        if (currentpc >= cur_end) begin
          result_d = MemtoRegOut;
          state_d  = StCheck;
        end else if (wdog_q == WdogLimit) begin
          fail_d  = fail_q | idx_onehot;
          to_d    = to_q | idx_onehot;
          state_d = StNext;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      StCheck: begin
        if (result_q == cur_expect) begin
          pass_d = pass_q + 5'd1;
        end else begin
          fail_d = fail_q | idx_onehot;
        end
        state_d = StNext;
      end
      StNext: begin
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d     = idx_q + 4'd1;
          wdog_d    = '0;
          rst_cnt_d = '0;
          state_d   = StCpuRst;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      pass_q    <= '0;
      fail_q    <= '0;
      to_q      <= '0;
      wdog_q    <= '0;
      rst_cnt_q <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      to_q      <= to_d;
      wdog_q    <= wdog_d;
      rst_cnt_q <= rst_cnt_d;
      result_q  <= result_d;
    end
  end

  // All outputs decode directly from state so reset reaches them without a clock.
  assign cpu_resetl   = !(state_q inside {StIdle, StCpuRst});
  assign cpu_startpc  = (state_q == StIdle) ? '0 : cur_start;
  assign busy         = !(state_q inside {StIdle, StDone});
  assign done         = (state_q == StDone);
  assign all_passed   = done && (pass_q == NumProgs);
  assign pass_count   = pass_q;
  assign fail_mask    = fail_q;
  assign timeout_mask = to_q;
  assign prog_idx     = idx_q;

endmodule
